// File: rtl/data_m_copy_engine.sv
// Block-copy initiator on the data_m bus: reads a word, writes it back out, repeats.
// Every access waits for its ack, bounded by a per-access timeout that aborts the copy.
module data_m_copy_engine #(
   parameter int ADDR_WIDTH = 19,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [15:0]           count,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] data_m_addr,
   output logic [15:0]           data_m_data_out,
   input  logic [15:0]           data_m_data_in,
   output logic                  data_m_access,
   output logic                  data_m_wr_en,
   output logic [1:0]            data_m_bytesel,
   input  logic                  data_m_ack
);

   typedef enum logic [2:0] {IDLE, READ, GAP_R, WRITE, GAP_W, FINISH} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
   localparam logic [15:0]           WAIT_LIMIT = 16'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [15:0]           remaining_q, remaining_d;
   logic [15:0]           wait_q, wait_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           data_out_q, data_out_d;
   logic                  access_q, access_d;
   logic                  wr_en_q, wr_en_d;
   logic                  ack_v;

   // A late duplicate ack from a registered responder lands while access is low.
   assign ack_v = data_m_ack & access_q;

   always_comb begin
      // NOTE: every _d starts at its held value so no path through the case infers a latch.
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      remaining_d = remaining_q;
      wait_d      = wait_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      addr_d      = addr_q;
      data_out_d  = data_out_q;
      access_d    = access_q;
      wr_en_d     = wr_en_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               src_d       = src_addr;
               dst_d       = dst_addr;
               remaining_d = count;
               error_d     = 1'b0;
               busy_d      = 1'b1;
               if (count == 16'd0) begin
                  state_d = FINISH;
               end else begin
                  state_d  = READ;
                  access_d = 1'b1;
                  wr_en_d  = 1'b0;
                  addr_d   = src_addr;
                  wait_d   = 16'd0;
               end
            end
         end
         READ: begin
            if (ack_v) begin
               data_out_d = data_m_data_in;
               access_d   = 1'b0;
               state_d    = GAP_R;
            end else if (wait_q == WAIT_LIMIT) begin
               access_d = 1'b0;
               wr_en_d  = 1'b0;
               error_d  = 1'b1;
               state_d  = FINISH;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         GAP_R: begin
            state_d  = WRITE;
            access_d = 1'b1;
            wr_en_d  = 1'b1;
            addr_d   = dst_q;
            wait_d   = 16'd0;
         end
         WRITE: begin
            if (ack_v) begin
               access_d    = 1'b0;
               wr_en_d     = 1'b0;
               src_d       = src_q + ADDR_ONE;
               dst_d       = dst_q + ADDR_ONE;
               remaining_d = remaining_q - 16'd1;
               state_d     = (remaining_q == 16'd1) ? FINISH : GAP_W;
            end else if (wait_q == WAIT_LIMIT) begin
               access_d = 1'b0;
               wr_en_d  = 1'b0;
               error_d  = 1'b1;
               state_d  = FINISH;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         GAP_W: begin
            state_d  = READ;
            access_d = 1'b1;
            wr_en_d  = 1'b0;
            addr_d   = src_q;
            wait_d   = 16'd0;
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         remaining_q <= '0;
         wait_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         addr_q      <= '0;
         data_out_q  <= '0;
         access_q    <= 1'b0;
         wr_en_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         remaining_q <= remaining_d;
         wait_q      <= wait_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         addr_q      <= addr_d;
         data_out_q  <= data_out_d;
         access_q    <= access_d;
         wr_en_q     <= wr_en_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign data_m_addr     = addr_q;
   assign data_m_data_out = data_out_q;
   assign data_m_access   = access_q;
   assign data_m_wr_en    = wr_en_q;
   assign data_m_bytesel  = 2'b11;

endmodule

// File: tb/tb_data_m_copy_engine.sv
// Bench for data_m_copy_engine: a sparse-memory responder, a word-by-word copy model
// feeding an expected-access queue, and a per-cycle bus monitor.
module tb_data_m_copy_engine;

   localparam int AW = 19;
   localparam int TO = 8;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } acc_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [15:0]   count = '0;
   logic          busy, done, error;
   logic [AW-1:0] data_m_addr;
   logic [15:0]   data_m_data_out;
   logic [15:0]   data_m_data_in = '0;
   logic          data_m_access, data_m_wr_en;
   logic [1:0]    data_m_bytesel;
   logic          data_m_ack = 1'b0;

   data_m_copy_engine #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
      .busy(busy), .done(done), .error(error),
      .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
      .data_m_data_in(data_m_data_in), .data_m_access(data_m_access),
      .data_m_wr_en(data_m_wr_en), .data_m_bytesel(data_m_bytesel),
      .data_m_ack(data_m_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Responder memory, model shadow memory and expected-access queue
   logic [15:0]   mem [logic [AW-1:0]];
   logic [15:0]   ref_mem [logic [AW-1:0]];
   acc_t          exp_q [$];
   logic [AW:0]   log_q [$];

   // Responder configuration
   bit            rand_lat = 0;
   bit            dup_ack = 0;
   bit            no_ack_en = 0;
   logic [AW-1:0] no_ack_addr = '0;
   int            cur_lat = 1;
   int            lat_cnt = 0;
   int            ack_phase = 0;

   // Per-run observations
   int n_acc, acc_rises, wr_rises, acc_hi, done_cnt, done_cyc, busy_cycles, start_edge;

   logic          acc_prev = 1'b0;
   logic          wr_prev = 1'b0;
   logic [AW-1:0] addr_prev = '0;
   logic [15:0]   dout_prev = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] dflt(input logic [AW-1:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] rd_mem(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic logic [15:0] rd_ref(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // Copy model: word i is read from src+i then written to dst+i, addresses mod 2^AW.
   task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
      ref_mem = mem;
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] sa;
         logic [AW-1:0] da;
         logic [15:0]   w;
         sa = AW'(s + i);
         da = AW'(d + i);
         w  = rd_ref(sa);
         exp_q.push_back('{wr: 1'b0, addr: sa, data: w});
         exp_q.push_back('{wr: 1'b1, addr: da, data: w});
         ref_mem[da] = w;
      end
   endtask

   // Monitor plus responder, evaluated once per cycle at the falling edge
   always @(negedge clk) begin
      if (reset) begin
         data_m_ack = 1'b0;
         ack_phase  = 0;
         lat_cnt    = 0;
         acc_prev   = 1'b0;
      end else begin
         check("bytesel", 32'(data_m_bytesel), 32'h3);
         if (data_m_access) check("access_implies_busy", 32'(busy), 32'h1);
         if (done) check("done_implies_not_busy", 32'(busy), 32'h0);
         if (acc_prev && data_m_ack) check("access_drops_after_ack", 32'(data_m_access), 32'h0);
         if (acc_prev && !data_m_ack && data_m_access) begin
            check("hold_addr", 32'(data_m_addr), 32'(addr_prev));
            check("hold_wr_en", 32'(data_m_wr_en), 32'(wr_prev));
            if (data_m_wr_en) check("hold_wdata", 32'(data_m_data_out), 32'(dout_prev));
         end
         if (data_m_access) acc_hi++;
         if (data_m_access && !acc_prev) begin
            acc_rises++;
            if (data_m_wr_en) wr_rises++;
         end
         if (busy) busy_cycles++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         acc_prev  = data_m_access;
         wr_prev   = data_m_wr_en;
         addr_prev = data_m_addr;
         dout_prev = data_m_data_out;

         if (ack_phase == 1 && dup_ack) begin
            ack_phase = 2;
         end else begin
            data_m_ack = 1'b0;
            ack_phase  = 0;
            if (data_m_access && !(no_ack_en && data_m_addr == no_ack_addr)) begin
               lat_cnt++;
               if (lat_cnt > cur_lat) begin
                  data_m_ack = 1'b1;
                  ack_phase  = 1;
                  lat_cnt    = 0;
                  cur_lat    = rand_lat ? int'($urandom_range(1, 5)) : 1;
                  n_acc++;
                  log_q.push_back({data_m_wr_en, data_m_addr});
                  if (exp_q.size() == 0) begin
                     check("unexpected_access", 32'h1, 32'h0);
                  end else begin
                     acc_t e;
                     e = exp_q.pop_front();
                     check("acc_wr_en", 32'(data_m_wr_en), 32'(e.wr));
                     check("acc_addr", 32'(data_m_addr), 32'(e.addr));
                     if (e.wr) check("acc_wdata", 32'(data_m_data_out), 32'(e.data));
                  end
                  if (data_m_wr_en) mem[data_m_addr] = data_m_data_out;
                  else data_m_data_in = rd_mem(data_m_addr);
               end
            end else begin
               lat_cnt = 0;
            end
         end
      end
   end

   task automatic clear_counters();
      n_acc = 0; acc_rises = 0; wr_rises = 0; acc_hi = 0;
      done_cnt = 0; done_cyc = 0; busy_cycles = 0;
      log_q.delete();
   endtask

   task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [15:0] n);
      @(negedge clk); #1;
      src_addr = s; dst_addr = d; count = n; start = 1'b1;
      start_edge = cyc + 1;
      @(negedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'h1);
      check("error_cleared_by_start", 32'(error), 32'h0);
   endtask

   task automatic wait_done(input int budget, input int mid_start);
      int waited = 0;
      while (done_cnt == 0 && waited < budget) begin
         @(negedge clk); #1;
         if (waited == mid_start) begin
            start = 1'b1; src_addr = 19'h05555; dst_addr = 19'h06666; count = 16'd7;
         end else begin
            start = 1'b0;
         end
         waited++;
      end
      start = 1'b0;
      if (done_cnt == 0) check("done_within_budget", 32'h0, 32'h1);
   endtask

   task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                           input int exp_lat, input int mid_start, input int budget);
      clear_counters();
      cur_lat = rand_lat ? int'($urandom_range(1, 5)) : 1;
      model_copy(s, d, n);
      do_start(s, d, 16'(n));
      wait_done(budget, mid_start);
      if (exp_lat >= 0) check("done_latency", 32'(done_cyc - start_edge), 32'(exp_lat));
      repeat (3) @(negedge clk);
      #1;
      check("done_pulses", 32'(done_cnt), 32'h1);
      check("acked_accesses", 32'(n_acc), 32'(2 * n));
      check("expected_queue_drained", 32'(exp_q.size()), 32'h0);
      check("error_after_copy", 32'(error), 32'h0);
      check("busy_after_copy", 32'(busy), 32'h0);
      for (int i = 0; i < n; i++)
         check("dst_word", 32'(rd_mem(AW'(d + i))), 32'(rd_ref(AW'(d + i))));
   endtask

   initial begin
      logic [AW:0] wrap_exp [6];
      wrap_exp = '{{1'b0, 19'h7FFFF}, {1'b1, 19'h7FFFE}, {1'b0, 19'h00000},
                   {1'b1, 19'h7FFFF}, {1'b0, 19'h00001}, {1'b1, 19'h00000}};

      // Reset state
      #12;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_error", 32'(error), 32'h0);
      check("rst_access", 32'(data_m_access), 32'h0);
      check("rst_wr_en", 32'(data_m_wr_en), 32'h0);
      check("rst_addr", 32'(data_m_addr), 32'h0);
      check("rst_wdata", 32'(data_m_data_out), 32'h0);
      check("rst_bytesel", 32'(data_m_bytesel), 32'h3);
      @(negedge clk); #1 reset = 1'b0;

      // Four-word copy with a 1-cycle responder: done 24 cycles after start
      mem[19'h00100] = 16'h1111; mem[19'h00101] = 16'h2222;
      mem[19'h00102] = 16'h3333; mem[19'h00103] = 16'h4444;
      run_copy(19'h00100, 19'h00200, 4, 24, -1, 100);
      check("copy4_word0", 32'(rd_mem(19'h00200)), 32'h1111);
      check("copy4_word1", 32'(rd_mem(19'h00201)), 32'h2222);
      check("copy4_word2", 32'(rd_mem(19'h00202)), 32'h3333);
      check("copy4_word3", 32'(rd_mem(19'h00203)), 32'h4444);
      check("copy4_acks", 32'(n_acc), 32'd8);

      // Zero-length copy: done one cycle after start, no bus traffic
      run_copy(19'h00300, 19'h00400, 0, 1, -1, 20);
      check("count0_no_access", 32'(acc_rises), 32'h0);
      check("count0_busy_cycles", 32'(busy_cycles), 32'h1);

      // Independent wrap of source and destination at the top of the address space
      mem[19'h7FFFF] = 16'hAAAA; mem[19'h00000] = 16'hBBBB; mem[19'h00001] = 16'hCCCC;
      run_copy(19'h7FFFF, 19'h7FFFE, 3, 18, -1, 100);
      check("wrap_log_len", 32'(log_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < log_q.size(); i++)
         check("wrap_access", 32'(log_q[i]), 32'(wrap_exp[i]));
      check("wrap_dst_7fffe", 32'(rd_mem(19'h7FFFE)), 32'hAAAA);
      check("wrap_dst_7ffff", 32'(rd_mem(19'h7FFFF)), 32'hBBBB);
      check("wrap_dst_00000", 32'(rd_mem(19'h00000)), 32'hCCCC);

      // Unacked read: abort after TIMEOUT wait cycles, no write, sticky error
      clear_counters();
      exp_q.delete();
      no_ack_en = 1; no_ack_addr = 19'h12345;
      do_start(19'h12345, 19'h00500, 16'd2);
      wait_done(60, -1);
      check("timeout_latency", 32'(done_cyc - start_edge), 32'(TO + 1));
      check("timeout_access_cycles", 32'(acc_hi), 32'(TO));
      check("timeout_one_access", 32'(acc_rises), 32'h1);
      check("timeout_no_write", 32'(wr_rises), 32'h0);
      check("timeout_error", 32'(error), 32'h1);
      check("timeout_busy", 32'(busy), 32'h0);
      no_ack_en = 0;
      run_copy(19'h12345, 19'h00600, 1, 6, -1, 40);

      // Duplicate acks, variable latency, and a start pulse while busy
      for (int i = 0; i < 5; i++) mem[AW'(19'h01000 + i)] = 16'(16'h0A10 + 16'h0101 * i);
      rand_lat = 1; dup_ack = 1;
      run_copy(19'h01000, 19'h02000, 5, -1, 7, 300);
      check("midstart_ignored", 32'(rd_mem(19'h06666)), 32'(dflt(19'h06666)));
      rand_lat = 0; dup_ack = 0;

      // Reset during the second write of a four-word copy
      clear_counters();
      model_copy(19'h03000, 19'h03100, 4);
      do_start(19'h03000, 19'h03100, 16'd4);
      begin
         int waited = 0;
         while (wr_rises < 2 && waited < 100) begin
            @(negedge clk); #1;
            waited++;
         end
         if (wr_rises < 2) check("second_write_reached", 32'h0, 32'h1);
      end
      check("pre_reset_write_active", 32'(data_m_access & data_m_wr_en), 32'h1);
      #1 reset = 1'b1;
      #1;
      check("midrst_access", 32'(data_m_access), 32'h0);
      check("midrst_wr_en", 32'(data_m_wr_en), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      check("midrst_addr", 32'(data_m_addr), 32'h0);
      check("midrst_wdata", 32'(data_m_data_out), 32'h0);
      exp_q.delete();
      @(negedge clk); #1 reset = 1'b0;
      clear_counters();
      repeat (6) @(negedge clk);
      #1;
      check("midrst_no_done", 32'(done_cnt), 32'h0);
      check("midrst_no_access", 32'(acc_rises), 32'h0);
      run_copy(19'h03000, 19'h03200, 2, 12, -1, 60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
